count_run_arbiter: RTL and testbench

COUNT_RUN_ARBITER -- requirements
Module: count_run_arbiter

---
 rtl/count_pkg.sv | 17 +
 rtl/run_counter.sv | 54 +++++
 rtl/count_run_arbiter.sv | 138 +++++++++++++
 tb/tb_count_run_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared constants, FSM state type and limit legality helper for the count-run arbiter.
package count_pkg;

    localparam int unsigned LIM_MAX = 9;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // A run limit is usable only when it lies in 1..lim_max.
    function automatic logic lim_legal(input logic [CNT_W-1:0] lim, input int unsigned lim_max);
        return (lim != '0) && (32'(lim) <= lim_max);
    endfunction

endpackage

// File: rtl/run_counter.sv
// Bounded run counter: counts 0..limit, flags the wrap, and can step the limit for staircase runs.
module run_counter #(
    parameter int unsigned LIM_MAX = count_pkg::LIM_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          enable,
    input  logic                          advance,
    input  logic [count_pkg::CNT_W-1:0]   load_lim,
    output logic [count_pkg::CNT_W-1:0]   count,
    output logic                          wrap
);
    import count_pkg::*;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;

    assign wrap  = (count_q == limit_q);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        if (clear) begin
            count_d = '0;
            if (load) begin
                limit_d = load_lim;
            end
        end else if (enable) begin
            if (wrap) begin
                count_d = '0;
                // Staircase step: the largest limit folds back to the shortest run.
                if (advance) begin
                    limit_d = (limit_q == CNT_W'(LIM_MAX)) ? CNT_W'(1) : limit_q + CNT_W'(1);
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/count_run_arbiter.sv
// Two-requester round-robin arbiter that lends one shared bounded counter to the granted owner.
module count_run_arbiter #(
    parameter int unsigned LIM_MAX = count_pkg::LIM_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req,
    input  logic [count_pkg::CNT_W-1:0]   lim0,
    input  logic [count_pkg::CNT_W-1:0]   lim1,
    input  logic                          stair,
    output logic [1:0]                    grant,
    output logic                          busy,
    output logic [count_pkg::CNT_W-1:0]   count,
    output logic [1:0]                    done,
    output logic                          err
);
    import count_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q, done_d;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic             stair_q, stair_d;

    logic [1:0]       legal;
    logic [1:0]       elig;
    logic             owner_req;
    logic             pick1;

    logic             cnt_clear;
    logic             cnt_load;
    logic             cnt_enable;
    logic             cnt_advance;
    logic             cnt_wrap;
    logic [CNT_W-1:0] cnt_lim;

    assign legal     = {lim_legal(lim1, LIM_MAX), lim_legal(lim0, LIM_MAX)};
    assign elig      = req & legal;
    assign owner_req = |(req & grant_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = 2'b00;
        err_d       = 1'b0;
        last_d      = last_q;
        stair_d     = stair_q;
        pick1       = 1'b0;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_enable  = 1'b0;
        cnt_advance = 1'b0;
        cnt_lim     = lim0;
        case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                // Rejection is reported even when the other requester is granted this edge.
                err_d     = |(req & ~legal);
                if (|elig) begin
                    pick1     = elig[1] && (!elig[0] || !last_q);
                    state_d   = StRun;
                    grant_d   = pick1 ? 2'b10 : 2'b01;
                    last_d    = pick1;
                    stair_d   = stair;
                    cnt_load  = 1'b1;
                    cnt_lim   = pick1 ? lim1 : lim0;
                end
            end
            StRun: begin
                if (cnt_wrap) begin
                    // Completion beats a same-cycle request drop.
                    done_d     = grant_q;
                    cnt_enable = 1'b1;
                    if (stair_q && owner_req) begin
                        cnt_advance = 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = 2'b00;
                    end
                end else if (!owner_req) begin
                    state_d   = StIdle;
                    grant_d   = 2'b00;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
            stair_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
            stair_q <= stair_d;
        end
    end

    run_counter #(
        .LIM_MAX (LIM_MAX)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .enable   (cnt_enable),
        .advance  (cnt_advance),
        .load_lim (cnt_lim),
        .count    (count),
        .wrap     (cnt_wrap)
    );

    assign grant = grant_q;
    assign busy  = (state_q == StRun);
    assign done  = done_q;
    assign err   = err_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_done_onehot  : assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
    a_idle_count   : assert property (@(posedge clk) disable iff (rst)
                                      (state_q == StIdle) |-> (count == '0));

endmodule

// File: tb/tb_count_run_arbiter.sv
// Table-driven, queue-scoreboarded bench for count_run_arbiter.
module tb_count_run_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] lim0 = 4'd0;
    logic [3:0] lim1 = 4'd0;
    logic       stair = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic [3:0] count;
    logic [1:0] done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic       st;
        logic [9:0] exp;
    } vec_t;

    vec_t       tv[$];
    logic [9:0] exp_q[$];

    count_run_arbiter #(
        .LIM_MAX (9)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lim0  (lim0),
        .lim1  (lim1),
        .stair (stair),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pack(input logic [1:0] g, input logic b, input logic [3:0] c,
                                        input logic [1:0] d, input logic e);
        return {g, b, c, d, e};
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [9:0] exp);
        logic [9:0] act;
        act = {grant, busy, count, done, err};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got grant=%b busy=%b count=%0d done=%b err=%b, want grant=%b busy=%b count=%0d done=%b err=%b",
                     nm, idx, act[9:8], act[7], act[6:3], act[2:1], act[0],
                     exp[9:8], exp[7], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic add(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                       input logic st, input logic [1:0] g, input logic b, input logic [3:0] c,
                       input logic [1:0] d, input logic e);
        vec_t v;
        v.req = r; v.l0 = l0; v.l1 = l1; v.st = st; v.exp = pack(g, b, c, d, e);
        tv.push_back(v);
    endtask

    // Each vector: drive inputs, expect outputs after the following rising edge.
    task automatic run_table(input string nm);
        for (int i = 0; i < tv.size(); i++) begin
            req = tv[i].req; lim0 = tv[i].l0; lim1 = tv[i].l1; stair = tv[i].st;
            exp_q.push_back(tv[i].exp);
            @(posedge clk);
            #1;
            cmp(nm, i, exp_q.pop_front());
        end
        tv.delete();
    endtask

    task automatic pulse_reset();
        req = 2'b00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    int lims[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1};

    initial begin
        #3;
        cmp("reset", 0, pack(2'b00, 1'b0, 4'd0, 2'b00, 1'b0));
        @(posedge clk);
        #1;
        cmp("reset_held", 0, pack(2'b00, 1'b0, 4'd0, 2'b00, 1'b0));
        rst = 1'b0;

        // Single run, req dropped on the completion cycle.
        add(2'b01, 3, 0, 0, 2'b01, 1, 0, 2'b00, 0);
        add(2'b01, 3, 0, 0, 2'b01, 1, 1, 2'b00, 0);
        add(2'b01, 3, 0, 0, 2'b01, 1, 2, 2'b00, 0);
        add(2'b01, 3, 0, 0, 2'b01, 1, 3, 2'b00, 0);
        add(2'b00, 3, 0, 0, 2'b00, 0, 0, 2'b01, 0);
        add(2'b00, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("single");

        // Contention after reset: 0,1,0,1 with limit inputs disturbed mid-run.
        pulse_reset();
        for (int r = 0; r < 4; r++) begin
            logic [1:0] own;
            own = r[0] ? 2'b10 : 2'b01;
            if (r == 2) begin
                add(2'b11, 2, 2, 0, own, 1, 0, 2'b00, 0);
                add(2'b11, 9, 2, 1, own, 1, 1, 2'b00, 0);
                add(2'b11, 2, 2, 0, own, 1, 2, 2'b00, 0);
            end else begin
                for (int k = 0; k <= 2; k++) add(2'b11, 2, 2, 0, own, 1, k[3:0], 2'b00, 0);
            end
            add((r == 3) ? 2'b00 : 2'b11, 2, 2, 0, 2'b00, 0, 0, own, 0);
        end
        add(2'b00, 2, 2, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("contend");

        // Illegal limits: zero and above the maximum.
        add(2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2'b11, 1, 0, 0, 2'b01, 1, 0, 2'b00, 1);
        add(2'b11, 1, 0, 0, 2'b01, 1, 1, 2'b00, 0);
        add(2'b10, 1, 0, 0, 2'b00, 0, 0, 2'b01, 0);
        add(2'b10, 1, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2'b00, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        add(2'b10, 1, 10, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2'b00, 1, 10, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("illegal");

        // Staircase 1..9 then wrap to 1, then drop req mid-run for an abort.
        add(2'b01, 1, 0, 1, 2'b01, 1, 0, 2'b00, 0);
        for (int j = 0; j < 10; j++) begin
            for (int k = 1; k <= lims[j]; k++) add(2'b01, 1, 0, 1, 2'b01, 1, k[3:0], 2'b00, 0);
            add(2'b01, 1, 0, 1, 2'b01, 1, 0, 2'b01, 0);
        end
        add(2'b01, 1, 0, 1, 2'b01, 1, 1, 2'b00, 0);
        add(2'b00, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("stair");

        // Abort at count 2 of a limit-5 run: no done.
        add(2'b01, 5, 0, 0, 2'b01, 1, 0, 2'b00, 0);
        add(2'b01, 5, 0, 0, 2'b01, 1, 1, 2'b00, 0);
        add(2'b01, 5, 0, 0, 2'b01, 1, 2, 2'b00, 0);
        add(2'b00, 5, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        add(2'b00, 5, 0, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("abort");

        // Reset mid-run at count 4, then requester 0 must win a tie.
        for (int k = 0; k <= 4; k++) add(2'b01, 5, 0, 0, 2'b01, 1, k[3:0], 2'b00, 0);
        run_table("prerst");
        #2;
        rst = 1'b1;
        #1;
        cmp("rst_mid", 0, pack(2'b00, 1'b0, 4'd0, 2'b00, 1'b0));
        req = 2'b11; lim0 = 4'd2; lim1 = 4'd2;
        #1;
        rst = 1'b0;
        add(2'b11, 2, 2, 0, 2'b01, 1, 0, 2'b00, 0);
        add(2'b00, 2, 2, 0, 2'b00, 0, 0, 2'b00, 0);
        run_table("postrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
